seg_display_driver: RTL and testbench

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_display_driver.sv | 139 +++++++++++++
 tb/tb_seg_display_driver.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seg_display_driver.sv
// seg_display_driver: binary-to-BCD converter feeding a scanned 4-digit seven-segment display
module seg_display_driver #(
  parameter int REFRESH_TICKS = 100000,
  parameter int CONV_BITS     = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CONV_BITS-1:0] number,
  input  logic [1:0]           mode,
  input  logic [1:0]           select,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [3:0]           an
);
  localparam int SW = REFRESH_TICKS > 1 ? $clog2(REFRESH_TICKS) : 1;
  localparam logic [CONV_BITS-1:0] MAXV = CONV_BITS'(9999);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [CONV_BITS-1:0] samp_q, samp_d;
  logic [15:0] bcd_q, bcd_d, adj, disp_bcd_q, disp_bcd_d;
  logic [3:0] cnt_q, cnt_d, nib;
  logic ovf_q, ovf_d, disp_ovf_q, disp_ovf_d, vld_q, vld_d, lz, dp_d;
  logic [1:0] src_sel_q, src_sel_d, src_mode_q, src_mode_d;
  logic [1:0] disp_sel_q, disp_sel_d, disp_mode_q, disp_mode_d, dig_q, dig_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [6:0] seg_d;
  logic [3:0] an_d;
  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h7F;
    endcase
  endfunction
  // converter: sample, double-dabble shift, then publish to the display registers
  always_comb begin
    state_d = state_q;
    samp_d = samp_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    src_sel_d = src_sel_q;
    src_mode_d = src_mode_q;
    disp_bcd_d = disp_bcd_q;
    disp_ovf_d = disp_ovf_q;
    disp_sel_d = disp_sel_q;
    disp_mode_d = disp_mode_q;
    vld_d = vld_q;
    for (int i = 0; i < 4; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    case (state_q)
      IDLE: begin
        samp_d = number > MAXV ? MAXV : number;
        ovf_d = number > MAXV;
        src_sel_d = select;
        src_mode_d = mode;
        bcd_d = '0;
        cnt_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, samp_d} = {adj[14:0], samp_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        state_d = cnt_q == 4'(CONV_BITS-1) ? DONE : SHIFT;
      end
      DONE: begin
        disp_bcd_d = bcd_q;
        disp_ovf_d = ovf_q;
        disp_sel_d = src_sel_q;
        disp_mode_d = src_mode_q;
        vld_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // digit scan and segment selection for the digit currently enabled
  always_comb begin
    scan_d = scan_q == SW'(REFRESH_TICKS-1) ? '0 : scan_q + SW'(1);
    dig_d = scan_q == SW'(REFRESH_TICKS-1) ? dig_q + 2'd1 : dig_q;
    nib = disp_bcd_q[{dig_q, 2'b00} +: 4];
    lz = dig_q == 2'd3 ? disp_bcd_q[15:12] == 4'd0 :
         dig_q == 2'd2 ? disp_bcd_q[15:8] == 8'd0 :
         dig_q == 2'd1 ? disp_bcd_q[15:4] == 12'd0 : 1'b0;
    seg_d = !vld_q ? 7'h7F :
            disp_sel_q == 2'd0 ? (dig_q == 2'd0 ? dec({2'b00, disp_mode_q}) : dig_q == 2'd3 ? 7'h3F : 7'h7F) :
            disp_ovf_q ? 7'h10 : lz ? 7'h7F : dec(nib);
    dp_d = !(vld_q && disp_sel_q != 2'd0 && disp_ovf_q);
    an_d = vld_q ? ~(4'b0001 << dig_q) : 4'b1111;
  end
  // all state, with seg/dp/an registered together so they switch on one edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      samp_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      src_sel_q <= '0;
      src_mode_q <= '0;
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
      disp_sel_q <= '0;
      disp_mode_q <= '0;
      vld_q <= 1'b0;
      scan_q <= '0;
      dig_q <= '0;
      seg <= 7'h7F;
      dp <= 1'b1;
      an <= 4'b1111;
    end else begin
      state_q <= state_d;
      samp_q <= samp_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      src_sel_q <= src_sel_d;
      src_mode_q <= src_mode_d;
      disp_bcd_q <= disp_bcd_d;
      disp_ovf_q <= disp_ovf_d;
      disp_sel_q <= disp_sel_d;
      disp_mode_q <= disp_mode_d;
      vld_q <= vld_d;
      scan_q <= scan_d;
      dig_q <= dig_d;
      seg <= seg_d;
      dp <= dp_d;
      an <= an_d;
    end
  end
endmodule

// File: tb/tb_seg_display_driver.sv
// tb_seg_display_driver: directed vectors for the seven-segment display driver
module tb_seg_display_driver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [13:0] number = '0;
  logic [1:0] mode = '0;
  logic [1:0] select = 2'd2;
  logic [6:0] seg;
  logic dp;
  logic [3:0] an;
  int n_chk = 0;
  int n_err = 0;
  int n = 0;
  logic [6:0] dg[4];
  logic [3:0] dpv;

  seg_display_driver #(.REFRESH_TICKS(4), .CONV_BITS(14)) dut (
    .clk(clk), .rst(rst), .number(number), .mode(mode), .select(select),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic sync_idle;
    while (n % 16 != 0) tick(1);
  endtask

  task automatic grab;
    for (int i = 0; i < 4; i++) dg[i] = 7'h55;
    dpv = 4'hA;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      case (an)
        4'b1110: begin dg[0] = seg; dpv[0] = dp; end
        4'b1101: begin dg[1] = seg; dpv[1] = dp; end
        4'b1011: begin dg[2] = seg; dpv[2] = dp; end
        4'b0111: begin dg[3] = seg; dpv[3] = dp; end
        default: ;
      endcase
    end
  endtask

  task automatic chk_digits(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                            input logic [6:0] d1, input logic [6:0] d0, input logic [3:0] dps);
    chk({tag, "_d3"}, 32'(dg[3]), 32'(d3));
    chk({tag, "_d2"}, 32'(dg[2]), 32'(d2));
    chk({tag, "_d1"}, 32'(dg[1]), 32'(d1));
    chk({tag, "_d0"}, 32'(dg[0]), 32'(d0));
    chk({tag, "_dp"}, 32'(dpv), 32'(dps));
  endtask

  initial begin
    tick(3);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_an", 32'(an), 32'hF);
    rst = 1'b1;
    n = 0;
    tick(16);
    chk("pre_an", 32'(an), 32'hF);
    chk("pre_seg", 32'(seg), 32'h7F);
    tick(1);
    chk("first_an", 32'(an), 32'hE);
    chk("first_seg", 32'(seg), 32'h40);
    chk("first_dp", 32'(dp), 32'h1);
    tick(4);
    chk("scan1_an", 32'(an), 32'hD);
    chk("scan1_seg", 32'(seg), 32'h7F);
    tick(4);
    chk("scan2_an", 32'(an), 32'hB);
    chk("scan2_seg", 32'(seg), 32'h7F);
    tick(4);
    chk("scan3_an", 32'(an), 32'h7);
    chk("scan3_seg", 32'(seg), 32'h7F);
    tick(4);
    chk("wrap_an", 32'(an), 32'hE);

    number = 14'd1234; select = 2'd3;
    tick(40); grab;
    chk_digits("v1234", 7'h79, 7'h24, 7'h30, 7'h19, 4'hF);

    number = 14'd16383;
    tick(40); grab;
    chk_digits("ovf", 7'h10, 7'h10, 7'h10, 7'h10, 4'h0);

    number = 14'd9999;
    tick(40); grab;
    chk_digits("v9999", 7'h10, 7'h10, 7'h10, 7'h10, 4'hF);

    select = 2'd0; mode = 2'd2;
    tick(40); grab;
    chk_digits("msel2", 7'h3F, 7'h7F, 7'h7F, 7'h24, 4'hF);

    mode = 2'd1;
    tick(40); grab;
    chk_digits("msel1", 7'h3F, 7'h7F, 7'h7F, 7'h79, 4'hF);

    select = 2'd2; number = 14'd305;
    tick(40); grab;
    chk_digits("v305", 7'h7F, 7'h30, 7'h40, 7'h12, 4'hF);

    sync_idle;
    number = 14'd7; select = 2'd1;
    tick(4);
    number = 14'd50;
    tick(12); grab;
    chk_digits("iso7", 7'h7F, 7'h7F, 7'h7F, 7'h78, 4'hF);
    tick(1); grab;
    chk_digits("iso50", 7'h7F, 7'h7F, 7'h12, 7'h40, 4'hF);

    sync_idle;
    number = 14'd5678; select = 2'd3;
    tick(8);
    rst = 1'b0;
    tick(1);
    chk("mrst_seg", 32'(seg), 32'h7F);
    chk("mrst_dp", 32'(dp), 32'h1);
    chk("mrst_an", 32'(an), 32'hF);
    rst = 1'b1;
    n = 0;
    tick(16);
    chk("mrel_an", 32'(an), 32'hF);
    chk("mrel_seg", 32'(seg), 32'h7F);
    tick(1);
    chk("mrel_first_an", 32'(an), 32'hE);
    chk("mrel_first_seg", 32'(seg), 32'h00);
    tick(3); grab;
    chk_digits("v5678", 7'h12, 7'h02, 7'h78, 7'h00, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
